// File: rtl/exe_wb_buffer_pkg.sv
// Shared packet types and default sizing for the execute-lane writeback buffer.
package exe_wb_buffer_pkg;

  localparam int PHY_REG_W    = 7;
  localparam int DATA_W       = 32;
  localparam int WB_BUF_DEPTH = 4;
  localparam int WB_BUF_SKID  = 2;

  typedef struct packed {
    logic                 valid;
    logic [PHY_REG_W-1:0] phyDest;
    logic [DATA_W-1:0]    destData;
  } wbPkt;

  typedef struct packed {
    logic                 valid;
    logic [PHY_REG_W-1:0] tag;
    logic [DATA_W-1:0]    data;
  } bypassPkt;

endpackage

// File: rtl/wb_buffer_fifo.sv
// In-order storage for the writeback buffer: pointers, occupancy, push/pop/flush.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module wb_buffer_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wrData_i,
  output logic [W-1:0]     rdData_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] countNext_o,
  output logic             full_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  always_comb begin
    doPop   = pop_i && !flush_i && (count_q != '0);
    doPush  = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || doPop);
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      if (doPush && !doPop)      count_d = count_q + 1'b1;
      else if (doPop && !doPush) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wrData_i;
  end

  assign rdData_o    = mem_q[rdPtr_q];
  assign count_o     = count_q;
  assign countNext_o = count_d;
  assign full_o      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/exe_wb_buffer.sv
// Writeback buffer for one execute lane: FIFO plus grant handshake, bypass, almostFull and overflow.
// Define EXE_WB_PERF_EN to build the stall/grant performance counters; otherwise they read 0.
module exe_wb_buffer
  import exe_wb_buffer_pkg::*;
#(
  parameter int DEPTH = WB_BUF_DEPTH,
  parameter int SKID  = WB_BUF_SKID,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recoverFlag_i,
  input  wbPkt             wbPacket_i,
  input  logic             wbGrant_i,
  output logic             wbReq_o,
  output wbPkt             wbPacket_o,
  output bypassPkt         bypassPacket_o,
  output logic             almostFull_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] stallCycles_o,
  output logic [CNT_W-1:0] grantCount_o
);

  localparam int PW      = PHY_REG_W + DATA_W;
  localparam int COUNT_W = $clog2(DEPTH + 1);
  localparam logic [COUNT_W-1:0] AF_THRESH = COUNT_W'(DEPTH - SKID);

  logic [PW-1:0]      headData;
  logic [COUNT_W-1:0] count, countNext;
  logic               full, push, pop;
  bypassPkt           bypass_q, bypass_d;
  logic               almostFull_q, almostFull_d;
  logic               overflow_q, overflow_d;

  assign push = wbPacket_i.valid && !recoverFlag_i;
  assign pop  = wbReq_o && wbGrant_i && !recoverFlag_i;

  wb_buffer_fifo #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) uFifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (recoverFlag_i),
    .push_i      (push),
    .pop_i       (pop),
    .wrData_i    ({wbPacket_i.phyDest, wbPacket_i.destData}),
    .rdData_o    (headData),
    .count_o     (count),
    .countNext_o (countNext),
    .full_o      (full)
  );

  assign wbReq_o = (count != '0);

  always_comb begin
    wbPacket_o.valid    = wbReq_o;
    wbPacket_o.phyDest  = headData[PW-1:DATA_W];
    wbPacket_o.destData = headData[DATA_W-1:0];
  end

  // A push into a full buffer with no pop is lost; flag it permanently.
  always_comb begin
    bypass_d       = '0;
    bypass_d.valid = pop;
    if (pop) begin
      bypass_d.tag  = headData[PW-1:DATA_W];
      bypass_d.data = headData[DATA_W-1:0];
    end
    almostFull_d = (countNext >= AF_THRESH);
    overflow_d   = overflow_q || (push && full && !pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bypass_q     <= '0;
      almostFull_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      bypass_q     <= bypass_d;
      almostFull_q <= almostFull_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bypassPacket_o = bypass_q;
  assign almostFull_o   = almostFull_q;
  assign overflow_o     = overflow_q;

`ifdef EXE_WB_PERF_EN
  logic [CNT_W-1:0] stallCycles_q, stallCycles_d;
  logic [CNT_W-1:0] grantCount_q, grantCount_d;

  // Saturating counters, deliberately untouched by recovery.
  always_comb begin
    stallCycles_d = stallCycles_q;
    grantCount_d  = grantCount_q;
    if (wbReq_o && !wbGrant_i && (stallCycles_q != '1)) stallCycles_d = stallCycles_q + 1'b1;
    if (pop && (grantCount_q != '1))                    grantCount_d  = grantCount_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCycles_q <= '0;
      grantCount_q  <= '0;
    end else begin
      stallCycles_q <= stallCycles_d;
      grantCount_q  <= grantCount_d;
    end
  end

  assign stallCycles_o = stallCycles_q;
  assign grantCount_o  = grantCount_q;
`else
  assign stallCycles_o = '0;
  assign grantCount_o  = '0;
`endif

endmodule

// File: tb/tb_exe_wb_buffer.sv
// Directed self-checking bench for exe_wb_buffer (DEPTH=4, SKID=2).
// Perf counter expectations follow EXE_WB_PERF_EN.
module tb_exe_wb_buffer;
  import exe_wb_buffer_pkg::*;

  logic        clk;
  logic        reset;
  logic        recoverFlag;
  wbPkt        wbPacketIn;
  logic        wbGrant;
  logic        wbReq;
  wbPkt        wbPacketOut;
  bypassPkt    bypassPacket;
  logic        almostFull;
  logic        overflow;
  logic [15:0] stallCycles;
  logic [15:0] grantCount;

  int checks = 0;
  int failures = 0;

  exe_wb_buffer #(.DEPTH(4), .SKID(2), .CNT_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .recoverFlag_i  (recoverFlag),
    .wbPacket_i     (wbPacketIn),
    .wbGrant_i      (wbGrant),
    .wbReq_o        (wbReq),
    .wbPacket_o     (wbPacketOut),
    .bypassPacket_o (bypassPacket),
    .almostFull_o   (almostFull),
    .overflow_o     (overflow),
    .stallCycles_o  (stallCycles),
    .grantCount_o   (grantCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] tag, input logic [31:0] data,
                               input logic grant, input logic recover);
    wbPacketIn.valid    = v;
    wbPacketIn.phyDest  = tag;
    wbPacketIn.destData = data;
    wbGrant             = grant;
    recoverFlag         = recover;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (wbReq !== 1'b0) begin failures++; $display("[TB] FAIL reset_wbReq got=%b exp=0", wbReq); end
    checks++; if (wbPacketOut.valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_pktValid got=%b exp=0", wbPacketOut.valid); end
    checks++; if (bypassPacket.valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_bypass got=%b exp=0", bypassPacket.valid); end
    checks++; if (almostFull !== 1'b0) begin failures++; $display("[TB] FAIL reset_almostFull got=%b exp=0", almostFull); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (stallCycles !== 16'd0 || grantCount !== 16'd0) begin failures++; $display("[TB] FAIL reset_perf got=%0d/%0d exp=0/0", stallCycles, grantCount); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    applyStimulus(1'b1, 7'd5, 32'hA5A5_0001, 1'b1, 1'b0);
    step();
    checks++; if (wbReq !== 1'b1) begin failures++; $display("[TB] FAIL single_req got=%b exp=1", wbReq); end
    checks++; if (wbPacketOut.phyDest !== 7'd5 || wbPacketOut.destData !== 32'hA5A5_0001) begin failures++; $display("[TB] FAIL single_head got=%0d/%h exp=5/a5a50001", wbPacketOut.phyDest, wbPacketOut.destData); end
    checks++; if (bypassPacket.valid !== 1'b0) begin failures++; $display("[TB] FAIL single_bypassEarly got=%b exp=0", bypassPacket.valid); end
    applyStimulus(1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
    step();
    checks++; if (bypassPacket.valid !== 1'b1 || bypassPacket.tag !== 7'd5 || bypassPacket.data !== 32'hA5A5_0001) begin failures++; $display("[TB] FAIL single_bypass got=%b/%0d/%h exp=1/5/a5a50001", bypassPacket.valid, bypassPacket.tag, bypassPacket.data); end
    checks++; if (wbReq !== 1'b0) begin failures++; $display("[TB] FAIL single_empty got=%b exp=0", wbReq); end
    applyStimulus(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
    step();
    checks++; if (bypassPacket.valid !== 1'b0) begin failures++; $display("[TB] FAIL single_bypassDrop got=%b exp=0", bypassPacket.valid); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 7'(i), 32'(100 + i), 1'b0, 1'b0);
      step();
      checks++; if (almostFull !== (i >= 2)) begin failures++; $display("[TB] FAIL fill_almostFull%0d got=%b exp=%b", i, almostFull, (i >= 2)); end
    end
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
      checks++; if (wbReq !== 1'b1 || wbPacketOut.phyDest !== 7'(i)) begin failures++; $display("[TB] FAIL drain_head%0d got=%b/%0d exp=1/%0d", i, wbReq, wbPacketOut.phyDest, i); end
      step();
      checks++; if (bypassPacket.valid !== 1'b1 || bypassPacket.tag !== 7'(i) || bypassPacket.data !== 32'(100 + i)) begin failures++; $display("[TB] FAIL drain_bypass%0d got=%b/%0d/%0d exp=1/%0d/%0d", i, bypassPacket.valid, bypassPacket.tag, bypassPacket.data, i, 100 + i); end
      checks++; if (almostFull !== ((4 - i) >= 2)) begin failures++; $display("[TB] FAIL drain_almostFull%0d got=%b exp=%b", i, almostFull, ((4 - i) >= 2)); end
    end
    checks++; if (wbReq !== 1'b0) begin failures++; $display("[TB] FAIL drain_empty got=%b exp=0", wbReq); end
    applyStimulus(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 7'(i), 32'(200 + i), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 7'd9, 32'd209, 1'b1, 1'b0);
    step();
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL full_pushPop_overflow got=%b exp=0", overflow); end
    checks++; if (bypassPacket.tag !== 7'd1 || wbPacketOut.phyDest !== 7'd2 || almostFull !== 1'b1) begin failures++; $display("[TB] FAIL full_pushPop_state got=%0d/%0d/%b exp=1/2/1", bypassPacket.tag, wbPacketOut.phyDest, almostFull); end
    applyStimulus(1'b1, 7'd10, 32'd210, 1'b0, 1'b0);
    step();
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL full_overflow got=%b exp=1", overflow); end
    for (int i = 0; i < 4; i++) begin
      logic [6:0] expTag;
      expTag = (i == 3) ? 7'd9 : 7'(i + 2);
      applyStimulus(1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
      step();
      checks++; if (bypassPacket.valid !== 1'b1 || bypassPacket.tag !== expTag) begin failures++; $display("[TB] FAIL full_drain%0d got=%b/%0d exp=1/%0d", i, bypassPacket.valid, bypassPacket.tag, expTag); end
    end
    checks++; if (wbReq !== 1'b0 || overflow !== 1'b1) begin failures++; $display("[TB] FAIL full_dropped got=%b/%b exp=0/1", wbReq, overflow); end
    applyStimulus(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_recover();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 7'(20 + i), 32'(300 + i), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 7'd23, 32'd303, 1'b1, 1'b1);
    step();
    checks++; if (wbReq !== 1'b0 || bypassPacket.valid !== 1'b0 || almostFull !== 1'b0) begin failures++; $display("[TB] FAIL recover_flush got=%b/%b/%b exp=0/0/0", wbReq, bypassPacket.valid, almostFull); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL recover_keepOverflow got=%b exp=1", overflow); end
    applyStimulus(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
    step();
    checks++; if (wbReq !== 1'b0) begin failures++; $display("[TB] FAIL recover_notStored got=%b exp=0", wbReq); end
    applyStimulus(1'b1, 7'd30, 32'd330, 1'b0, 1'b0);
    step();
    checks++; if (wbReq !== 1'b1 || wbPacketOut.phyDest !== 7'd30) begin failures++; $display("[TB] FAIL recover_restart got=%b/%0d exp=1/30", wbReq, wbPacketOut.phyDest); end
    applyStimulus(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 7'(40 + i), 32'(400 + i), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 7'd43, 32'd403, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 7'd44, 32'd404, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 7'd45, 32'd405, 1'b0, 1'b0);
    step();
    checks++; if (overflow !== 1'b1 || almostFull !== 1'b1) begin failures++; $display("[TB] FAIL async_pre got=%b/%b exp=1/1", overflow, almostFull); end
    applyStimulus(1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (wbReq !== 1'b0 || wbPacketOut.valid !== 1'b0 || bypassPacket.valid !== 1'b0 || almostFull !== 1'b0 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL async_clear got=%b/%b/%b/%b/%b exp=0/0/0/0/0", wbReq, wbPacketOut.valid, bypassPacket.valid, almostFull, overflow); end
    reset = 1'b0;
    applyStimulus(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
    step();
    checks++; if (wbReq !== 1'b0) begin failures++; $display("[TB] FAIL async_stayEmpty got=%b exp=0", wbReq); end
  endtask

  task automatic test_perf();
    logic [15:0] expStall, expGrant;
`ifdef EXE_WB_PERF_EN
    expStall = 16'd5;
    expGrant = 16'd3;
`else
    expStall = 16'd0;
    expGrant = 16'd0;
`endif
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 7'(50 + i), 32'(500 + i), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) step();
    applyStimulus(1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
    repeat (3) step();
    applyStimulus(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
    step();
    checks++; if (stallCycles !== expStall) begin failures++; $display("[TB] FAIL perf_stall got=%0d exp=%0d", stallCycles, expStall); end
    checks++; if (grantCount !== expGrant) begin failures++; $display("[TB] FAIL perf_grant got=%0d exp=%0d", grantCount, expGrant); end
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
    test_reset();
    test_single();
    test_fill_drain();
    test_full_push_pop();
    test_recover();
    test_async_reset();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
